// File: rtl/ctrl_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Control-bundle bit map, bubble value and forward-select codes.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int CTRL_ALUSRC   = 0;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMTOREG = 7;

    localparam logic [7:0] BUBBLE = 8'h0E;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic memwrite;
        logic memread;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline_if
// Purpose  : ID-stage control bundle in, per-stage control fields out.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipeline_if #(
    parameter int CTRL_W = 8,
    parameter int REG_AW = 5
) ();
    logic [CTRL_W-1:0] ctrl_i;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic [REG_AW-1:0] rd_i;
    logic              flush_i;

    logic              alusrc_ex_o;
    logic [1:0]        aluop_ex_o;
    logic [REG_AW-1:0] wreg_ex_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              memread_mem_o;
    logic              memwrite_mem_o;
    logic              regwrite_mem_o;
    logic [REG_AW-1:0] wreg_mem_o;
    logic              regwrite_wb_o;
    logic              memtoreg_wb_o;
    logic [REG_AW-1:0] wreg_wb_o;
    logic              stall_o;

    modport master (
        output ctrl_i, rs_i, rt_i, rd_i, flush_i,
        input  alusrc_ex_o, aluop_ex_o, wreg_ex_o, fwd_a_o, fwd_b_o,
               memread_mem_o, memwrite_mem_o, regwrite_mem_o, wreg_mem_o,
               regwrite_wb_o, memtoreg_wb_o, wreg_wb_o, stall_o
    );

    modport slave (
        input  ctrl_i, rs_i, rt_i, rd_i, flush_i,
        output alusrc_ex_o, aluop_ex_o, wreg_ex_o, fwd_a_o, fwd_b_o,
               memread_mem_o, memwrite_mem_o, regwrite_mem_o, wreg_mem_o,
               regwrite_wb_o, memtoreg_wb_o, wreg_wb_o, stall_o
    );
endinterface : ctrl_pipeline_if
`default_nettype wire

// File: rtl/ctrl_pipeline_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Purpose  : Operand forward select for one EX source register.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] src_i,
    input  wire logic              mem_regwrite_i,
    input  wire logic [REG_AW-1:0] mem_dst_i,
    input  wire logic              wb_regwrite_i,
    input  wire logic [REG_AW-1:0] wb_dst_i,
    output logic      [1:0]        sel_o
);

    // The younger producer in EX/MEM wins over MEM/WB; $0 never forwards.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_regwrite_i && (mem_dst_i != '0) && (mem_dst_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_dst_i != '0) && (wb_dst_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline
// Purpose  : ID/EX, EX/MEM, MEM/WB control registers, load-use stall, forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int REG_AW = 5
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    ctrl_pipeline_if.slave   bus
);

    logic [CTRL_W-1:0] ctrl_ex_d, ctrl_ex_q;
    logic [REG_AW-1:0] rs_ex_d,   rs_ex_q;
    logic [REG_AW-1:0] rt_ex_d,   rt_ex_q;
    logic [REG_AW-1:0] dst_ex_d,  dst_ex_q;
    mem_ctrl_t         ctrl_mem_d, ctrl_mem_q;
    logic [REG_AW-1:0] dst_mem_d, dst_mem_q;
    wb_ctrl_t          ctrl_wb_d, ctrl_wb_q;
    logic [REG_AW-1:0] dst_wb_d,  dst_wb_q;

    logic       hazard;
    logic       stall;
    logic       bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // RegDst is resolved at capture; the EX copy is retained but not consumed.
    logic unused_regdst_ex;
    assign unused_regdst_ex = ctrl_ex_q[CTRL_REGDST];

    always_comb begin
        hazard = ctrl_ex_q[CTRL_MEMREAD] && (rt_ex_q != '0) &&
                 ((rt_ex_q == bus.rs_i) || (rt_ex_q == bus.rt_i));
        stall  = hazard && !bus.flush_i;
        bubble = stall || bus.flush_i;

        ctrl_ex_d = bus.ctrl_i;
        rs_ex_d   = bus.rs_i;
        rt_ex_d   = bus.rt_i;
        dst_ex_d  = bus.ctrl_i[CTRL_REGDST] ? bus.rd_i : bus.rt_i;
        if (bubble) begin
            ctrl_ex_d = BUBBLE;
            rs_ex_d   = '0;
            rt_ex_d   = '0;
            dst_ex_d  = '0;
        end

        ctrl_mem_d.memtoreg = ctrl_ex_q[CTRL_MEMTOREG];
        ctrl_mem_d.regwrite = ctrl_ex_q[CTRL_REGWRITE];
        ctrl_mem_d.memwrite = ctrl_ex_q[CTRL_MEMWRITE];
        ctrl_mem_d.memread  = ctrl_ex_q[CTRL_MEMREAD];
        dst_mem_d           = dst_ex_q;

        ctrl_wb_d.memtoreg  = ctrl_mem_q.memtoreg;
        ctrl_wb_d.regwrite  = ctrl_mem_q.regwrite;
        dst_wb_d            = dst_mem_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_ex_q  <= '0;
            rs_ex_q    <= '0;
            rt_ex_q    <= '0;
            dst_ex_q   <= '0;
            ctrl_mem_q <= '0;
            dst_mem_q  <= '0;
            ctrl_wb_q  <= '0;
            dst_wb_q   <= '0;
        end else begin
            ctrl_ex_q  <= ctrl_ex_d;
            rs_ex_q    <= rs_ex_d;
            rt_ex_q    <= rt_ex_d;
            dst_ex_q   <= dst_ex_d;
            ctrl_mem_q <= ctrl_mem_d;
            dst_mem_q  <= dst_mem_d;
            ctrl_wb_q  <= ctrl_wb_d;
            dst_wb_q   <= dst_wb_d;
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i          (rs_ex_q),
        .mem_regwrite_i (ctrl_mem_q.regwrite),
        .mem_dst_i      (dst_mem_q),
        .wb_regwrite_i  (ctrl_wb_q.regwrite),
        .wb_dst_i       (dst_wb_q),
        .sel_o          (fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i          (rt_ex_q),
        .mem_regwrite_i (ctrl_mem_q.regwrite),
        .mem_dst_i      (dst_mem_q),
        .wb_regwrite_i  (ctrl_wb_q.regwrite),
        .wb_dst_i       (dst_wb_q),
        .sel_o          (fwd_b)
    );

    assign bus.alusrc_ex_o    = ctrl_ex_q[CTRL_ALUSRC];
    assign bus.aluop_ex_o     = ctrl_ex_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign bus.wreg_ex_o      = dst_ex_q;
    assign bus.fwd_a_o        = fwd_a;
    assign bus.fwd_b_o        = fwd_b;
    assign bus.memread_mem_o  = ctrl_mem_q.memread;
    assign bus.memwrite_mem_o = ctrl_mem_q.memwrite;
    assign bus.regwrite_mem_o = ctrl_mem_q.regwrite;
    assign bus.wreg_mem_o     = dst_mem_q;
    assign bus.regwrite_wb_o  = ctrl_wb_q.regwrite;
    assign bus.memtoreg_wb_o  = ctrl_wb_q.memtoreg;
    assign bus.wreg_wb_o      = dst_wb_q;
    assign bus.stall_o        = stall;

endmodule : ctrl_pipeline
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipeline
// Purpose  : Directed self-checking bench for ctrl_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipeline;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ctrl_pipeline_if #(.CTRL_W(8), .REG_AW(5)) bus ();

    ctrl_pipeline #(.CTRL_W(8), .REG_AW(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.alusrc_ex_o, bus.aluop_ex_o, bus.wreg_ex_o, bus.fwd_a_o,
                  bus.fwd_b_o, bus.memread_mem_o, bus.memwrite_mem_o,
                  bus.regwrite_mem_o, bus.wreg_mem_o, bus.regwrite_wb_o,
                  bus.memtoreg_wb_o, bus.wreg_wb_o, bus.stall_o}, 32'h0);
    endtask

    task automatic set_id(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic fl);
        bus.ctrl_i  = c;
        bus.rs_i    = rs;
        bus.rt_i    = rt;
        bus.rd_i    = rd;
        bus.flush_i = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_id(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        step();
        chk_all_zero("reset_outs");
        rst_n = 1'b1;

        // R-type through all three stages
        set_id(8'h4E, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        chk("rtype_wreg_ex", bus.wreg_ex_o, 3);
        chk("rtype_aluop_ex", bus.aluop_ex_o, 2'b11);
        chk("rtype_alusrc_ex", bus.alusrc_ex_o, 0);
        set_id(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("rtype_mem", {bus.regwrite_mem_o, bus.memread_mem_o, bus.wreg_mem_o}, {1'b1, 1'b0, 5'd3});
        step();
        chk("rtype_wb", {bus.regwrite_wb_o, bus.memtoreg_wb_o, bus.wreg_wb_o}, {1'b1, 1'b0, 5'd3});

        // Asynchronous reset mid-stream
        set_id(8'h4E, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        step();
        chk("pre_reset_mem", {bus.regwrite_mem_o, bus.wreg_mem_o}, {1'b1, 5'd3});
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outs");
        set_id(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk_all_zero("reset_hold_outs");
        rst_n = 1'b1;

        // Load-use: one stall cycle, bubble, then WB forward
        set_id(8'hD1, 5'd1, 5'd5, 5'd0, 1'b0);
        step();
        chk("lw_ex", {bus.alusrc_ex_o, bus.aluop_ex_o, bus.wreg_ex_o}, {1'b1, 2'b00, 5'd5});
        set_id(8'h4E, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        chk("lu_stall", bus.stall_o, 1);
        step();
        chk("lu_stall_drop", bus.stall_o, 0);
        chk("lu_bubble_ex", {bus.alusrc_ex_o, bus.aluop_ex_o, bus.wreg_ex_o}, {1'b0, 2'b11, 5'd0});
        chk("lu_lw_mem", {bus.memread_mem_o, bus.regwrite_mem_o, bus.wreg_mem_o}, {1'b1, 1'b1, 5'd5});
        step();
        chk("lu_fwd_a", bus.fwd_a_o, 2'b01);
        chk("lu_fwd_b", bus.fwd_b_o, 2'b00);
        chk("lu_consumer_ex", bus.wreg_ex_o, 7);
        chk("lu_bubble_mem", {bus.memread_mem_o, bus.regwrite_mem_o}, 2'b00);
        chk("lu_lw_wb", {bus.regwrite_wb_o, bus.memtoreg_wb_o, bus.wreg_wb_o}, {1'b1, 1'b1, 5'd5});

        // Forward priority: EX/MEM over MEM/WB
        set_id(8'h4E, 5'd0, 5'd0, 5'd4, 1'b0);
        step();
        step();
        set_id(8'h4E, 5'd4, 5'd9, 5'd10, 1'b0);
        step();
        chk("prio_fwd_a", bus.fwd_a_o, 2'b10);
        chk("prio_fwd_b", bus.fwd_b_o, 2'b00);
        set_id(8'h4E, 5'd0, 5'd10, 5'd11, 1'b0);
        step();
        chk("memfwd_b", {bus.fwd_a_o, bus.fwd_b_o}, {2'b00, 2'b10});
        set_id(8'h4E, 5'd0, 5'd10, 5'd13, 1'b0);
        step();
        chk("wbfwd_b", {bus.fwd_a_o, bus.fwd_b_o}, {2'b00, 2'b01});

        // $0 guard for forwarding and stall
        set_id(8'h4E, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        set_id(8'h4E, 5'd0, 5'd0, 5'd1, 1'b0);
        step();
        chk("zero_fwd", {bus.fwd_a_o, bus.fwd_b_o}, 4'b0000);
        chk("zero_mem", {bus.regwrite_mem_o, bus.wreg_mem_o}, {1'b1, 5'd0});
        set_id(8'hD1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        set_id(8'h4E, 5'd0, 5'd0, 5'd2, 1'b0);
        #1;
        chk("zero_stall", bus.stall_o, 0);

        // Flush collides with a load-use hazard
        set_id(8'hD1, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        set_id(8'h4E, 5'd8, 5'd0, 5'd3, 1'b1);
        #1;
        chk("flush_stall", bus.stall_o, 0);
        step();
        chk("flush_bubble_ex", {bus.aluop_ex_o, bus.wreg_ex_o}, {2'b11, 5'd0});
        chk("flush_lw_mem", {bus.memread_mem_o, bus.wreg_mem_o}, {1'b1, 5'd8});

        // Hazard through the rt comparison
        set_id(8'hD1, 5'd0, 5'd9, 5'd0, 1'b0);
        step();
        set_id(8'h4E, 5'd1, 5'd9, 5'd3, 1'b0);
        #1;
        chk("rt_stall", bus.stall_o, 1);
        step();
        chk("rt_stall_drop", {bus.stall_o, bus.wreg_ex_o}, {1'b0, 5'd0});

        // Store reaches MEM with MemWrite only
        set_id(8'h21, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        set_id(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("sw_mem", {bus.memwrite_mem_o, bus.memread_mem_o, bus.regwrite_mem_o}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ctrl_pipeline
`default_nettype wire
